nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
Downstream stage of the 4-bit bus-split/select datapath. It consumes the 4-bit result nibble stream P, one nibble per valid/ready transfer, and packs NIBS nibbles into one wide word W. W is presented on a valid/ready output handshake. A flush request emits a partially filled word, zero-padded, for end-of-stream.

Parameters:
NIB_W, 4, width of each input nibble (matches P width)
NIBS, 4, nibbles per output word; WW = NIB_W*NIBS
LSB_FIRST, 1, 1: first nibble lands in W[NIB_W-1:0]; 0: first nibble lands in the top slice

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
P  input  NIB_W  nibble data from upstream select stage
in_valid  input  1  P is valid this cycle
in_ready  output  1  packer accepts P this cycle
flush  input  1  level request to emit the partial word
flush_ack  output  1  one-cycle pulse when a flush is executed or discarded
W  output  WW  packed output word
out_nibs  output  $clog2(NIBS+1)  number of valid nibbles in W
out_valid  output  1  W/out_nibs are valid
out_ready  input  1  consumer accepts W this cycle

Behaviour:
- One clock domain. rst_n is asynchronous active-low; assertion clears all state immediately.
- Reset values: acc=0, cnt=0, W=0, out_nibs=0, out_valid=0, flush_ack=0. in_ready=1 after reset.
- State: accumulator acc[WW-1:0], fill count cnt (0..NIBS-1), output register {W, out_nibs, out_valid}.
- Definitions:
  - slot_free = !out_valid || out_ready (combinational).
  - in_ready = !flush && (cnt != NIBS-1 || slot_free). This is a combinational path out_ready -> in_ready.
  - Accept = in_valid && in_ready.
- On accept, the nibble is written to slice index cnt (LSB_FIRST=1) or NIBS-1-cnt (LSB_FIRST=0).
- When the accept is the NIBS-th nibble:
  - The completed word (acc merged with the new nibble) loads into W on the same edge.
  - out_nibs=NIBS, out_valid=1.
  - acc clears to 0 and cnt returns to 0.
  - Latency is 1 clock from the last nibble accept to out_valid.
- Otherwise an accept increments cnt.
- Output handshake:
  - out_valid && out_ready retires the word.
  - out_valid drops next cycle unless a new word loads on the same edge. Back-to-back loads are allowed, giving full throughput of one nibble per clock.
  - While out_valid && !out_ready, W and out_nibs are held stable.
- Flush (priority over input; in_ready=0 while flush=1):
  - cnt==0: the flush is discarded; flush_ack pulses for 1 cycle and no output is produced.
  - cnt>0 and slot_free: acc (unfilled slices zero) loads into W, out_nibs=cnt, out_valid=1. acc and cnt clear, flush_ack pulses.
  - cnt>0 and !slot_free: wait; no state change. Flush is executed on the first slot_free cycle.
  - The source deasserts flush in the cycle after flush_ack. If flush is still high, it is re-evaluated (normally cnt==0, so the next flush_ack is a discard).
- Overflow is impossible: a full word never overwrites an un-retired output because in_ready blocks.
- Reset mid-fill or mid-hold discards the partial word and the pending output. No output is produced after reset until new nibbles arrive.
- in_valid without in_ready, and out_ready without out_valid, have no effect.

Test Plan:
- Basic packing:
  - Stimulus: NIBS=4, LSB_FIRST=1, out_ready=1; P=1,2,3,4 on consecutive clocks.
  - Required response: one clock after the 4th accept, out_valid=1, W=16'h4321, out_nibs=4. out_valid is 1 for exactly 1 cycle.
- MSB-first order:
  - Stimulus: LSB_FIRST=0; same nibbles 1,2,3,4.
  - Required response: W=16'h1234.
- Backpressure:
  - Stimulus: out_ready=0. Send 8 nibbles 0..7 continuously, then release out_ready after 5 stalled cycles.
  - Required response:
    - First word 16'h3210 is held stable while stalled.
    - in_ready=0 while cnt==3 and output is blocked.
    - Second word 16'h7654 follows the first with no lost or duplicated nibble.
- Flush:
  - Stimulus: send A,B, then assert flush.
  - Required response: W=16'h00BA, out_nibs=2, flush_ack=1 for one cycle, cnt=0 afterwards. A flush with cnt==0 gives flush_ack and no out_valid.
- Flush blocked:
  - Stimulus: output holding an un-retired word with out_ready=0; 1 nibble in acc; assert flush.
  - Required response: flush waits. When out_ready rises, the old word retires and the partial word loads on the same edge.
- Async reset:
  - Stimulus: drop rst_n mid-clock with cnt=2 and out_valid=1.
  - Required response: out_valid=0 and W=0 immediately, without waiting for a clock edge. After release, the next 4 nibbles produce a clean word.

Source files
------------

// File: rtl/nibble_packer_if.sv
// Handshake bundle for the nibble packer: nibble input stream, flush request, packed word output.
interface nibble_packer_if #(
  parameter int unsigned NIB_W = 4,
  parameter int unsigned NIBS  = 4
);
  localparam int unsigned WW = NIB_W * NIBS;
  localparam int unsigned CW = $clog2(NIBS + 1);

  logic [NIB_W-1:0] P;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             flush_ack;
  logic [WW-1:0]    W;
  logic [CW-1:0]    out_nibs;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output P, in_valid, flush, out_ready,
    input  in_ready, flush_ack, W, out_nibs, out_valid
  );

  modport slave (
    input  P, in_valid, flush, out_ready,
    output in_ready, flush_ack, W, out_nibs, out_valid
  );
endinterface

// File: rtl/nibble_packer.sv
// Packs NIBS nibbles into one wide word on a valid/ready output; flush emits a zero-padded
// partial word for end-of-stream.
module nibble_packer #(
  parameter int unsigned NIB_W     = 4,
  parameter int unsigned NIBS      = 4,
  parameter bit          LSB_FIRST = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  nibble_packer_if.slave bus
);
  localparam int unsigned WW = NIB_W * NIBS;
  localparam int unsigned CW = $clog2(NIBS + 1);
  localparam int unsigned SW = (WW > 1) ? $clog2(WW) : 1;

  logic [WW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] w_q, w_d;
  logic [CW-1:0] nibs_q, nibs_d;
  logic          valid_q, valid_d;
  logic          ack_q, ack_d;

  logic          slot_free;
  logic          last_slot;
  logic          in_ready_c;
  logic          accept;
  logic [CW-1:0] idx;
  logic [SW-1:0] shamt;
  logic [WW-1:0] merged;

  // Handshake qualifiers; in_ready is combinational from out_ready so a full word can
  // retire and the next one load on the same edge.
  assign slot_free  = !valid_q || bus.out_ready;
  assign last_slot  = (cnt_q == CW'(NIBS - 1));
  assign in_ready_c = !bus.flush && (!last_slot || slot_free);
  assign accept     = bus.in_valid && in_ready_c;

  // Place the incoming nibble into its slice; unfilled slices of acc are always zero.
  assign idx    = LSB_FIRST ? cnt_q : (CW'(NIBS - 1) - cnt_q);
  assign shamt  = SW'(idx * NIB_W);
  assign merged = acc_q | (WW'(bus.P) << shamt);

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    nibs_d  = nibs_q;
    valid_d = valid_q;
    ack_d   = 1'b0;

    if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end

    if (bus.flush) begin
      // Flush wins over input; an empty accumulator just acknowledges.
      if (cnt_q == '0) begin
        ack_d = 1'b1;
      end else if (slot_free) begin
        w_d     = acc_q;
        nibs_d  = cnt_q;
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        ack_d   = 1'b1;
      end
    end else if (accept) begin
      if (last_slot) begin
        w_d     = merged;
        nibs_d  = CW'(NIBS);
        valid_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
      end else begin
        acc_d = merged;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      w_q     <= '0;
      nibs_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
      nibs_q  <= nibs_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.flush_ack = ack_q;
  assign bus.W         = w_q;
  assign bus.out_nibs  = nibs_q;
  assign bus.out_valid = valid_q;
endmodule

// File: tb/tb_nibble_packer.sv
// Drives an LSB-first and an MSB-first packer with identical stimulus; output words are
// checked against a scoreboard filled as nibbles and flushes are issued.
module tb_nibble_packer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] nib;
  logic       in_valid;
  logic       flush;
  logic       out_ready;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct packed {
    logic [15:0] w;
    logic [2:0]  n;
  } exp_t;

  exp_t       q_lsb[$];
  exp_t       q_msb[$];
  logic [3:0] cur[$];

  nibble_packer_if #(.NIB_W(4), .NIBS(4)) lsb_if ();
  nibble_packer_if #(.NIB_W(4), .NIBS(4)) msb_if ();

  assign lsb_if.P         = nib;
  assign lsb_if.in_valid  = in_valid;
  assign lsb_if.flush     = flush;
  assign lsb_if.out_ready = out_ready;
  assign msb_if.P         = nib;
  assign msb_if.in_valid  = in_valid;
  assign msb_if.flush     = flush;
  assign msb_if.out_ready = out_ready;

  nibble_packer #(.NIB_W(4), .NIBS(4), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .bus(lsb_if.slave)
  );
  nibble_packer #(.NIB_W(4), .NIBS(4), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .bus(msb_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Convert the nibbles sent since the last word into expected words for both orders.
  task automatic push_expected();
    logic [15:0] wl = '0;
    logic [15:0] wm = '0;
    exp_t        e;
    for (int i = 0; i < cur.size(); i++) begin
      wl |= 16'(cur[i]) << (4 * i);
      wm |= 16'(cur[i]) << (4 * (3 - i));
    end
    e = {wl, 3'(cur.size())};
    q_lsb.push_back(e);
    e = {wm, 3'(cur.size())};
    q_msb.push_back(e);
    cur.delete();
  endtask

  // Offer one nibble from just after a falling edge; returns on the falling edge after accept.
  task automatic send(input logic [3:0] p);
    int guard = 0;
    nib      = p;
    in_valid = 1'b1;
    #1;
    while (!lsb_if.in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("send_in_ready_timeout", 32'(guard < 50), 32'(1));
    @(posedge clk);
    cur.push_back(p);
    if (cur.size() == 4) push_expected();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Scoreboard: a word retires on the coming edge when valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    #3;
    if (rst_n && lsb_if.out_valid && lsb_if.out_ready) begin
      n_checks++;
      assert (q_lsb.size() != 0) else begin
        n_err++;
        $error("FAIL lsb_unexpected_word observed=%0h expected=none", lsb_if.W);
      end
      if (q_lsb.size() != 0) begin
        e = q_lsb.pop_front();
        chk("lsb_word", 32'(lsb_if.W), 32'(e.w));
        chk("lsb_nibs", 32'(lsb_if.out_nibs), 32'(e.n));
      end
    end
    if (rst_n && msb_if.out_valid && msb_if.out_ready) begin
      n_checks++;
      assert (q_msb.size() != 0) else begin
        n_err++;
        $error("FAIL msb_unexpected_word observed=%0h expected=none", msb_if.W);
      end
      if (q_msb.size() != 0) begin
        e = q_msb.pop_front();
        chk("msb_word", 32'(msb_if.W), 32'(e.w));
        chk("msb_nibs", 32'(msb_if.out_nibs), 32'(e.n));
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    nib       = '0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(lsb_if.in_ready), 32'(1));
    chk("rst_out_valid", 32'(lsb_if.out_valid), 32'(0));
    chk("rst_w", 32'(lsb_if.W), 32'(0));
    chk("rst_out_nibs", 32'(lsb_if.out_nibs), 32'(0));
    chk("rst_flush_ack", 32'(lsb_if.flush_ack), 32'(0));

    // Basic packing, both orders
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    #1;
    chk("basic_valid", 32'(lsb_if.out_valid), 32'(1));
    chk("basic_w_lsb", 32'(lsb_if.W), 32'h4321);
    chk("basic_w_msb", 32'(msb_if.W), 32'h1234);
    chk("basic_nibs", 32'(lsb_if.out_nibs), 32'(4));
    @(negedge clk); #1;
    chk("basic_valid_one_cycle", 32'(lsb_if.out_valid), 32'(0));

    // Backpressure: eight nibbles against a stalled consumer
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(4'(i));
    nib      = 4'h7;
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready_blocked", 32'(lsb_if.in_ready), 32'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("bp_hold_w", 32'(lsb_if.W), 32'h3210);
      chk("bp_hold_valid", 32'(lsb_if.out_valid), 32'(1));
      chk("bp_in_ready_stall", 32'(lsb_if.in_ready), 32'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(lsb_if.in_ready), 32'(1));
    @(posedge clk);
    cur.push_back(4'h7);
    push_expected();
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("bp_second_w_lsb", 32'(lsb_if.W), 32'h7654);
    chk("bp_second_w_msb", 32'(msb_if.W), 32'h4567);
    chk("bp_second_valid", 32'(lsb_if.out_valid), 32'(1));
    @(negedge clk);

    // Flush a partial word, then flush with an empty accumulator
    send(4'hA); send(4'hB);
    flush = 1'b1;
    push_expected();
    #1;
    chk("flush_in_ready", 32'(lsb_if.in_ready), 32'(0));
    @(posedge clk); @(negedge clk); #1;
    chk("flush_ack", 32'(lsb_if.flush_ack), 32'(1));
    chk("flush_valid", 32'(lsb_if.out_valid), 32'(1));
    chk("flush_w_lsb", 32'(lsb_if.W), 32'h00BA);
    chk("flush_w_msb", 32'(msb_if.W), 32'hAB00);
    chk("flush_nibs", 32'(lsb_if.out_nibs), 32'(2));
    flush = 1'b0;
    @(negedge clk); #1;
    chk("flush_ack_pulse", 32'(lsb_if.flush_ack), 32'(0));
    chk("flush_valid_drop", 32'(lsb_if.out_valid), 32'(0));
    flush = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("discard_ack", 32'(lsb_if.flush_ack), 32'(1));
    chk("discard_no_valid", 32'(lsb_if.out_valid), 32'(0));
    flush = 1'b0;
    @(negedge clk); #1;
    chk("discard_ack_pulse", 32'(lsb_if.flush_ack), 32'(0));
    @(negedge clk);

    // Flush blocked behind an un-retired word
    out_ready = 1'b0;
    send(4'hC); send(4'hD); send(4'hE); send(4'hF);
    send(4'h9);
    flush = 1'b1;
    push_expected();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fblk_no_ack", 32'(lsb_if.flush_ack), 32'(0));
      chk("fblk_hold_w", 32'(lsb_if.W), 32'hFEDC);
      chk("fblk_hold_nibs", 32'(lsb_if.out_nibs), 32'(4));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    chk("fblk_ack", 32'(lsb_if.flush_ack), 32'(1));
    chk("fblk_valid", 32'(lsb_if.out_valid), 32'(1));
    chk("fblk_w_lsb", 32'(lsb_if.W), 32'h0009);
    chk("fblk_w_msb", 32'(msb_if.W), 32'h9000);
    chk("fblk_nibs", 32'(lsb_if.out_nibs), 32'(1));
    flush = 1'b0;
    @(negedge clk); @(negedge clk);

    // Asynchronous reset with a held word and two nibbles in the accumulator
    out_ready = 1'b0;
    send(4'h1); send(4'h2); send(4'h3); send(4'h4);
    send(4'h5); send(4'h6);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(lsb_if.out_valid), 32'(0));
    chk("arst_w_lsb", 32'(lsb_if.W), 32'(0));
    chk("arst_w_msb", 32'(msb_if.W), 32'(0));
    chk("arst_nibs", 32'(lsb_if.out_nibs), 32'(0));
    chk("arst_in_ready", 32'(lsb_if.in_ready), 32'(1));
    q_lsb.delete();
    q_msb.delete();
    cur.delete();
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send(4'h7); send(4'h8); send(4'h9); send(4'hA);
    #1;
    chk("post_rst_valid", 32'(lsb_if.out_valid), 32'(1));
    chk("post_rst_w_lsb", 32'(lsb_if.W), 32'hA987);
    chk("post_rst_w_msb", 32'(msb_if.W), 32'h789A);
    chk("post_rst_nibs", 32'(lsb_if.out_nibs), 32'(4));

    repeat (3) @(negedge clk);
    #4;
    chk("lsb_queue_drained", 32'(q_lsb.size()), 32'(0));
    chk("msb_queue_drained", 32'(q_msb.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
